n64_btn_events: RTL and testbench

Button-event stage sitting directly downstream of the N64 controller poller on the same APB fabric. It takes each completed 32-bit controller sample and its one-cycle completion pulse. It derives press/release edges for the 16 button bits and queues one event word per changed sample in a FIFO. The CPU drains the FIFO over APB and is interrupted while events are pending.

---
 rtl/n64_btn_events_if.sv | 22 ++
 rtl/n64_btn_events.sv | 128 ++++++++++++
 tb/tb_n64_btn_events.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/n64_btn_events_if.sv
// APB3 slave bus bundle for the N64 button-event block.
// The CPU side drives the control/address/write-data signals; the block returns data and status.
interface n64_btn_events_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/n64_btn_events.sv
// Turns N64 controller samples into press/release event words, queues them in a FIFO,
// and lets the CPU drain them over APB with a level interrupt while events are pending.
module n64_btn_events #(
    parameter int DEPTH = 16
) (
    input  logic               PCLK,
    input  logic               PRESETN,
    input  logic [31:0]        ctrl_word,
    input  logic               ctrl_valid,
    n64_btn_events_if.slave    apb,
    output logic               irq
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] REG_STATUS  = 6'd0;
    localparam logic [5:0] REG_EVENT   = 6'd1;
    localparam logic [5:0] REG_CURRENT = 6'd2;
    localparam logic [5:0] REG_CTRL    = 6'd3;

    logic [15:0]   prev_q, prev_d;
    logic [15:0]   stick_q, stick_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          irq_en_q, irq_en_d;
    logic [31:0]   mem_q [DEPTH];

    logic [15:0] btn_new, rise, fall;
    logic [5:0]  reg_idx;
    logic        rd_access, wr_access;
    logic        empty, full;
    logic        push_req, push, pop, flush, ovf_set, ovf_clr;
    logic        unused_bits;

    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA[31:3]};

    assign reg_idx   = apb.PADDR[7:2];
    assign rd_access = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
    assign wr_access = apb.PSEL & apb.PENABLE &  apb.PWRITE;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));

    // Reserved bits 23:22 sit at positions 7:6 of the button half-word.
    assign btn_new  = ctrl_word[31:16] & 16'hFF3F;
    assign rise     = btn_new & ~prev_q;
    assign fall     = ~btn_new & prev_q;
    assign push_req = ctrl_valid & ((rise | fall) != '0);

    assign pop     = rd_access & (reg_idx == REG_EVENT) & ~empty;
    assign flush   = wr_access & (reg_idx == REG_CTRL) & apb.PWDATA[1];
    assign ovf_clr = wr_access & (reg_idx == REG_CTRL) & apb.PWDATA[2];
    assign push    = push_req & ~flush & (~full | pop);
    assign ovf_set = push_req & ~flush & full & ~pop;

    // NOTE: every variable gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        prev_d   = prev_q;
        stick_d  = stick_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

        if (ctrl_valid) begin
            prev_d  = btn_new;
            stick_d = ctrl_word[15:0];
        end

        if (wr_access && reg_idx == REG_CTRL) begin
            irq_en_d = apb.PWDATA[0];
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            prev_q   <= '0;
            stick_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            irq_en_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            stick_q  <= stick_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            irq_en_q <= irq_en_d;
        end
    end

    // NOTE: the storage array is not reset; an entry is only ever read after count says it was written.
    always_ff @(posedge PCLK) begin
        if (push) mem_q[wr_ptr_q] <= {rise, fall};
    end

    always_comb begin
        apb.PRDATA = '0;
        case (reg_idx)
            REG_STATUS:  apb.PRDATA = {16'd0, {(8 - CW){1'b0}}, count_q, 5'd0, ovf_q, full, empty};
            REG_EVENT:   apb.PRDATA = empty ? 32'd0 : mem_q[rd_ptr_q];
            REG_CURRENT: apb.PRDATA = {prev_q, stick_q};
            REG_CTRL:    apb.PRDATA = {31'd0, irq_en_q};
            default:     apb.PRDATA = '0;
        endcase
    end

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;
    assign irq         = irq_en_q & ~empty;
endmodule

// File: tb/tb_n64_btn_events.sv
// Directed self-checking bench for n64_btn_events: edge detection, FIFO order,
// overflow, simultaneous push/pop at full, flush and interrupt behaviour.
module tb_n64_btn_events;
    localparam int DEPTH = 16;

    localparam logic [7:0] A_STATUS  = 8'h00;
    localparam logic [7:0] A_EVENT   = 8'h04;
    localparam logic [7:0] A_CURRENT = 8'h08;
    localparam logic [7:0] A_CTRL    = 8'h0C;

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic [31:0] ctrl_word = '0;
    logic        ctrl_valid = 1'b0;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    n64_btn_events_if apb ();

    n64_btn_events #(.DEPTH(DEPTH)) dut (
        .PCLK       (PCLK),
        .PRESETN    (PRESETN),
        .ctrl_word  (ctrl_word),
        .ctrl_valid (ctrl_valid),
        .apb        (apb),
        .irq        (irq)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Two-phase APB read; optionally fires a controller sample in the access cycle.
    task automatic apb_read(input logic [7:0] addr, input bit with_sample,
                            input logic [31:0] word, output logic [31:0] data);
        @(negedge PCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = addr;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        if (with_sample) begin
            ctrl_word  = word;
            ctrl_valid = 1'b1;
        end
        #1 data = apb.PRDATA;
        @(negedge PCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        ctrl_valid  = 1'b0;
    endtask

    task automatic apb_write(input logic [7:0] addr, input logic [31:0] data);
        @(negedge PCLK);
        apb.PSEL    = 1'b1;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b1;
        apb.PADDR   = addr;
        apb.PWDATA  = data;
        @(negedge PCLK);
        apb.PENABLE = 1'b1;
        @(negedge PCLK);
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
    endtask

    task automatic sample(input logic [31:0] word);
        @(negedge PCLK);
        ctrl_word  = word;
        ctrl_valid = 1'b1;
        @(negedge PCLK);
        ctrl_valid = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(addr, 1'b0, 32'd0, d);
        check(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        apb.PSEL    = 1'b0;
        apb.PENABLE = 1'b0;
        apb.PWRITE  = 1'b0;
        apb.PADDR   = '0;
        apb.PWDATA  = '0;

        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;

        rd_check("reset_status", A_STATUS, 32'h0000_0001);
        rd_check("reset_current", A_CURRENT, 32'h0000_0000);
        check("reset_irq", {31'd0, irq}, 32'd0);

        sample(32'h00C0_7F81);
        rd_check("reserved_nopush", A_STATUS, 32'h0000_0001);
        rd_check("reserved_current", A_CURRENT, 32'h0000_7F81);

        apb_write(A_CTRL, 32'h1);
        rd_check("ctrl_readback", A_CTRL, 32'h1);
        sample(32'h8000_0000);
        check("irq_after_push", {31'd0, irq}, 32'd1);
        rd_check("status_count1", A_STATUS, 32'h0000_0100);
        rd_check("event_a_press", A_EVENT, 32'h8000_0000);
        check("irq_after_drain", {31'd0, irq}, 32'd0);
        rd_check("status_drained", A_STATUS, 32'h0000_0001);
        rd_check("pop_on_empty", A_EVENT, 32'h0000_0000);
        rd_check("status_after_empty_pop", A_STATUS, 32'h0000_0001);

        sample(32'h8000_0000);
        sample(32'h1000_0000);
        sample(32'h1000_0000);
        rd_check("status_one_change", A_STATUS, 32'h0000_0100);
        rd_check("event_start_a", A_EVENT, 32'h1000_8000);
        sample(32'h0000_0000);
        rd_check("event_start_rel", A_EVENT, 32'h0000_1000);
        rd_check("unmapped_read", 8'h10, 32'h0000_0000);

        // DEPTH+1 alternating samples: the last push finds the queue full.
        for (int i = 0; i <= DEPTH; i++) sample((i % 2 == 0) ? 32'h8000_0000 : 32'h0);
        rd_check("status_overflow", A_STATUS, 32'h0000_1006);
        check("irq_full", {31'd0, irq}, 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            apb_read(A_EVENT, 1'b0, 32'd0, d);
            check($sformatf("drain_%0d", i), d, (i % 2 == 0) ? 32'h8000_0000 : 32'h0000_8000);
        end
        rd_check("status_ovf_sticky", A_STATUS, 32'h0000_0005);
        apb_write(A_CTRL, 32'h5);
        rd_check("status_ovf_clear", A_STATUS, 32'h0000_0001);

        // prev now holds A pressed; refill starting with a release.
        for (int i = 0; i < DEPTH; i++) sample((i % 2 == 0) ? 32'h0 : 32'h8000_0000);
        rd_check("status_refill", A_STATUS, 32'h0000_1002);
        apb_read(A_EVENT, 1'b1, 32'h0000_12AB, d);
        check("coincident_head", d, 32'h0000_8000);
        rd_check("status_push_pop_full", A_STATUS, 32'h0000_1002);
        apb_read(A_EVENT, 1'b0, 32'd0, d);
        check("order_after_coincident", d, 32'h8000_0000);

        sample(32'h8000_0000);
        apb_write(A_CTRL, 32'h3);
        rd_check("status_flushed", A_STATUS, 32'h0000_0001);
        rd_check("current_after_flush", A_CURRENT, 32'h8000_0000);
        check("irq_after_flush", {31'd0, irq}, 32'd0);

        sample(32'h0000_0055);
        rd_check("status_before_reset", A_STATUS, 32'h0000_0100);
        @(negedge PCLK);
        PRESETN = 1'b0;
        apb.PADDR = A_STATUS;
        #1 check("midreset_status", apb.PRDATA, 32'h0000_0001);
        apb.PADDR = A_CURRENT;
        #1 check("midreset_current", apb.PRDATA, 32'h0000_0000);
        check("midreset_irq", {31'd0, irq}, 32'd0);
        @(negedge PCLK);
        PRESETN = 1'b1;
        rd_check("post_reset_ctrl", A_CTRL, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
